// File: rtl/dma_csr_ctrl_if.sv
// dma_csr_ctrl_if: simplified MMIO bus between the HAL (master) and the DMA
// CSR block (slave).
//   mmio_rd_en    read strobe, one cycle per read
//   mmio_wr_en    write strobe, one cycle per write
//   mmio_rd_addr  read word address
//   mmio_wr_addr  write word address
//   mmio_wr_data  write data
//   mmio_rd_data  read data, valid the cycle after mmio_rd_en, held between reads
interface dma_csr_ctrl_if;
    logic        mmio_rd_en;
    logic        mmio_wr_en;
    logic [15:0] mmio_rd_addr;
    logic [15:0] mmio_wr_addr;
    logic [63:0] mmio_wr_data;
    logic [63:0] mmio_rd_data;

    modport master (
        output mmio_rd_en, mmio_wr_en, mmio_rd_addr, mmio_wr_addr, mmio_wr_data,
        input  mmio_rd_data
    );

    modport slave (
        input  mmio_rd_en, mmio_wr_en, mmio_rd_addr, mmio_wr_addr, mmio_wr_data,
        output mmio_rd_data
    );
endinterface

// File: rtl/dma_csr_ctrl.sv
// dma_csr_ctrl: DMA job CSR block. Decodes MMIO accesses into the DMA job
// registers, runs the IDLE/BUSY/DONE job FSM, issues a one-cycle start pulse,
// counts busy cycles and answers MMIO reads with a fixed 1-cycle latency.
//
// Ports:
//   clk          clock
//   rst_n        synchronous, active-low reset
//   mmio         MMIO bus (slave side of dma_csr_ctrl_if)
//   dma_rd_addr  source address register
//   dma_wr_addr  destination address register
//   dma_size     transfer length register
//   dma_go       one-cycle job start pulse
//   dma_done     datapath completion (level or pulse)
//   busy         high while a job is in flight
//
// Register map (word offsets from BASE_ADDR):
//   0x0 GO (WO)  0x2 RD_ADDR  0x4 WR_ADDR  0x6 SIZE  0x8 STATUS (RO)
//   0xA CYCLES (RO)  0xC CLEAR (WO)  0xE SCRATCH (only with DMA_CSR_SCRATCH_EN)
//
// Optional feature macro: DMA_CSR_SCRATCH_EN adds a 64-bit R/W scratch
// register at offset 0xE; without it that offset reads 0 and ignores writes.
module dma_csr_ctrl #(
    parameter logic [15:0] BASE_ADDR  = 16'h0050,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned SIZE_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dma_csr_ctrl_if.slave         mmio,
    output logic [ADDR_WIDTH-1:0] dma_rd_addr,
    output logic [ADDR_WIDTH-1:0] dma_wr_addr,
    output logic [SIZE_WIDTH-1:0] dma_size,
    output logic                  dma_go,
    input  logic                  dma_done,
    output logic                  busy
);

    localparam int unsigned CYC_WIDTH = 32;

    localparam logic [15:0] OFF_GO      = 16'h0000;
    localparam logic [15:0] OFF_RD_ADDR = 16'h0002;
    localparam logic [15:0] OFF_WR_ADDR = 16'h0004;
    localparam logic [15:0] OFF_SIZE    = 16'h0006;
    localparam logic [15:0] OFF_STATUS  = 16'h0008;
    localparam logic [15:0] OFF_CYCLES  = 16'h000A;
    localparam logic [15:0] OFF_CLEAR   = 16'h000C;
`ifdef DMA_CSR_SCRATCH_EN
    localparam logic [15:0] OFF_SCRATCH = 16'h000E;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [CYC_WIDTH-1:0] cycles;
    logic                 err;
`ifdef DMA_CSR_SCRATCH_EN
    logic [63:0]          scratch;
`endif

    // Offsets relative to BASE_ADDR; addresses below the base wrap to large
    // values and so fall into the unmapped default.
    logic [15:0] rd_off;
    logic [15:0] wr_off;
    assign rd_off = mmio.mmio_rd_addr - BASE_ADDR;
    assign wr_off = mmio.mmio_wr_addr - BASE_ADDR;

    logic wr_go, wr_rd_addr, wr_wr_addr, wr_size, wr_clear;
    logic go_req;

    always_comb begin
        wr_go      = 1'b0;
        wr_rd_addr = 1'b0;
        wr_wr_addr = 1'b0;
        wr_size    = 1'b0;
        wr_clear   = 1'b0;
        if (mmio.mmio_wr_en) begin
            case (wr_off)
                OFF_GO:      wr_go      = 1'b1;
                OFF_RD_ADDR: wr_rd_addr = 1'b1;
                OFF_WR_ADDR: wr_wr_addr = 1'b1;
                OFF_SIZE:    wr_size    = 1'b1;
                OFF_CLEAR:   wr_clear   = 1'b1;
                default:     ;
            endcase
        end
    end

    assign go_req = wr_go & mmio.mmio_wr_data[0];

    // Read mux works on current register values, so a same-cycle write to
    // the register being read returns the pre-write contents.
    logic [63:0] rd_value;

    always_comb begin
        rd_value = '0;
        case (rd_off)
            OFF_RD_ADDR: rd_value = 64'(dma_rd_addr);
            OFF_WR_ADDR: rd_value = 64'(dma_wr_addr);
            OFF_SIZE:    rd_value = 64'(dma_size);
            OFF_STATUS:  rd_value = {61'd0, err, busy, (state == DONE)};
            OFF_CYCLES:  rd_value = 64'(cycles);
`ifdef DMA_CSR_SCRATCH_EN
            OFF_SCRATCH: rd_value = scratch;
`endif
            default:     rd_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            cycles            <= '0;
            err               <= 1'b0;
            dma_rd_addr       <= '0;
            dma_wr_addr       <= '0;
            dma_size          <= '0;
            dma_go            <= 1'b0;
            busy              <= 1'b0;
            mmio.mmio_rd_data <= '0;
`ifdef DMA_CSR_SCRATCH_EN
            scratch           <= '0;
`endif
        end else begin
            dma_go <= 1'b0;

            if (mmio.mmio_rd_en) begin
                mmio.mmio_rd_data <= rd_value;
            end

`ifdef DMA_CSR_SCRATCH_EN
            if (mmio.mmio_wr_en && (wr_off == OFF_SCRATCH)) begin
                scratch <= mmio.mmio_wr_data;
            end
`endif

            case (state)
                IDLE, DONE: begin
                    if (wr_rd_addr) dma_rd_addr <= ADDR_WIDTH'(mmio.mmio_wr_data);
                    if (wr_wr_addr) dma_wr_addr <= ADDR_WIDTH'(mmio.mmio_wr_data);
                    if (wr_size)    dma_size    <= SIZE_WIDTH'(mmio.mmio_wr_data);
                    if (go_req) begin
                        state  <= BUSY;
                        busy   <= 1'b1;
                        dma_go <= 1'b1;
                        cycles <= '0;
                    end else if (wr_clear) begin
                        state  <= IDLE;
                        err    <= 1'b0;
                        cycles <= '0;
                    end
                end
                BUSY: begin
                    // Job registers are frozen while a job runs; any attempt
                    // to touch them (or restart) only flags an error.
                    if (wr_go || wr_rd_addr || wr_wr_addr || wr_size) begin
                        err <= 1'b1;
                    end
                    if (dma_done) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else if (cycles != '1) begin
                        cycles <= cycles + CYC_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_csr_ctrl.sv
// tb_dma_csr_ctrl: table-driven register-access vectors plus hand-written
// job sequences for dma_csr_ctrl.
module tb_dma_csr_ctrl;

    localparam logic [15:0] BASE = 16'h0050;

    logic        clk;
    logic        rst_n;
    logic [63:0] dma_rd_addr;
    logic [63:0] dma_wr_addr;
    logic [31:0] dma_size;
    logic        dma_go;
    logic        dma_done;
    logic        busy;

    dma_csr_ctrl_if mmio_bus ();

    dma_csr_ctrl #(
        .BASE_ADDR (16'h0050),
        .ADDR_WIDTH(64),
        .SIZE_WIDTH(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mmio       (mmio_bus.slave),
        .dma_rd_addr(dma_rd_addr),
        .dma_wr_addr(dma_wr_addr),
        .dma_size   (dma_size),
        .dma_go     (dma_go),
        .dma_done   (dma_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic        wr;
        logic [15:0] wa;
        logic [63:0] wd;
        logic        rd;
        logic [15:0] ra;
        logic        chk;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

`ifdef DMA_CSR_SCRATCH_EN
    localparam logic [63:0] SCRATCH_EXP = 64'hDEAD_BEEF;
`else
    localparam logic [63:0] SCRATCH_EXP = 64'h0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic mmio_write(input logic [15:0] off, input logic [63:0] data);
        mmio_bus.mmio_wr_en   = 1'b1;
        mmio_bus.mmio_wr_addr = BASE + off;
        mmio_bus.mmio_wr_data = data;
        tick();
        mmio_bus.mmio_wr_en   = 1'b0;
    endtask

    task automatic mmio_read_check(input string name, input logic [15:0] off, input logic [63:0] exp);
        mmio_bus.mmio_rd_en   = 1'b1;
        mmio_bus.mmio_rd_addr = BASE + off;
        tick();
        mmio_bus.mmio_rd_en   = 1'b0;
        check(name, mmio_bus.mmio_rd_data, exp);
    endtask

    initial begin
        rst_n                 = 1'b0;
        dma_done              = 1'b0;
        mmio_bus.mmio_rd_en   = 1'b0;
        mmio_bus.mmio_wr_en   = 1'b0;
        mmio_bus.mmio_rd_addr = '0;
        mmio_bus.mmio_wr_addr = '0;
        mmio_bus.mmio_wr_data = '0;

        // Register-access vectors: {wr, wr_off, wr_data, rd, rd_off, chk, expected}
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'h0, 1'b1, 64'h0});
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'h2, 1'b1, 64'h0});
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'h4, 1'b1, 64'h0});
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'h6, 1'b1, 64'h0});
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'h8, 1'b1, 64'h0});
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'hA, 1'b1, 64'h0});
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'hC, 1'b1, 64'h0});
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'hE, 1'b1, 64'h0});
        vecs.push_back('{1'b1, 16'h2, 64'h1000, 1'b0, 16'h0, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 16'h4, 64'h2000, 1'b0, 16'h0, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 16'h6, 64'hABCD_0000_0000_0010, 1'b0, 16'h0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'h2, 1'b1, 64'h1000});
        // output holds with no read strobe
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b0, 16'h4, 1'b1, 64'h1000});
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'h4, 1'b1, 64'h2000});
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'h6, 1'b1, 64'h10});
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'h0, 1'b1, 64'h0});
        // odd and out-of-range offsets
        vecs.push_back('{1'b1, 16'h3, 64'h55, 1'b1, 16'h3, 1'b1, 64'h0});
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'h2, 1'b1, 64'h1000});
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'h10, 1'b1, 64'h0});
        // read/write collision returns pre-write value
        vecs.push_back('{1'b1, 16'h2, 64'h3000, 1'b1, 16'h2, 1'b1, 64'h1000});
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'h2, 1'b1, 64'h3000});
        vecs.push_back('{1'b1, 16'h2, 64'h1000, 1'b0, 16'h0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 16'h0, 64'h0, 1'b1, 16'h2, 1'b1, 64'h1000});

        // Reset held for 3 cycles
        repeat (3) tick();
        check("rst_dma_go", 64'(dma_go), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_rd_data", mmio_bus.mmio_rd_data, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            mmio_bus.mmio_wr_en   = vecs[i].wr;
            mmio_bus.mmio_wr_addr = BASE + vecs[i].wa;
            mmio_bus.mmio_wr_data = vecs[i].wd;
            mmio_bus.mmio_rd_en   = vecs[i].rd;
            mmio_bus.mmio_rd_addr = BASE + vecs[i].ra;
            tick();
            mmio_bus.mmio_wr_en = 1'b0;
            mmio_bus.mmio_rd_en = 1'b0;
            if (vecs[i].chk) begin
                check($sformatf("vec%0d", i), mmio_bus.mmio_rd_data, vecs[i].exp);
            end
        end

        // Job 1: start, complete after 25 busy cycles
        mmio_write(16'h0, 64'h1);
        check("j1_go", 64'(dma_go), 64'h1);
        check("j1_busy", 64'(busy), 64'h1);
        check("j1_rd_addr", dma_rd_addr, 64'h1000);
        check("j1_wr_addr", dma_wr_addr, 64'h2000);
        check("j1_size", 64'(dma_size), 64'd16);
        tick();
        check("j1_go_pulse", 64'(dma_go), 64'h0);
        repeat (24) tick();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        check("j1_busy_end", 64'(busy), 64'h0);
        mmio_read_check("j1_status", 16'h8, 64'h1);
        mmio_read_check("j1_cycles", 16'hA, 64'd25);
        mmio_read_check("j1_cycles2", 16'hA, 64'd25);
        mmio_write(16'hC, 64'h0);
        mmio_read_check("j1_clr_status", 16'h8, 64'h0);
        mmio_read_check("j1_clr_cycles", 16'hA, 64'h0);

        // Job 2: writes while busy are blocked and flag err
        mmio_write(16'h0, 64'h1);
        check("j2_go", 64'(dma_go), 64'h1);
        mmio_write(16'h6, 64'd99);
        check("j2_no_go_a", 64'(dma_go), 64'h0);
        mmio_write(16'h0, 64'h1);
        check("j2_no_go_b", 64'(dma_go), 64'h0);
        tick();
        check("j2_no_go_c", 64'(dma_go), 64'h0);
        mmio_read_check("j2_size", 16'h6, 64'd16);
        mmio_write(16'hC, 64'h0);
        mmio_read_check("j2_status_busy", 16'h8, 64'h6);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        mmio_read_check("j2_status_done", 16'h8, 64'h5);
        // restart directly from DONE
        mmio_write(16'h0, 64'h1);
        check("j2_rego", 64'(dma_go), 64'h1);
        check("j2_rebusy", 64'(busy), 64'h1);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        mmio_write(16'hC, 64'h0);
        mmio_read_check("j2_clr_status", 16'h8, 64'h0);

        // Job 3: reset mid-job
        mmio_write(16'h0, 64'h1);
        check("j3_busy", 64'(busy), 64'h1);
        rst_n = 1'b0;
        tick();
        check("j3_rst_busy", 64'(busy), 64'h0);
        check("j3_rst_go", 64'(dma_go), 64'h0);
        check("j3_rst_rd_addr", dma_rd_addr, 64'h0);
        check("j3_rst_wr_addr", dma_wr_addr, 64'h0);
        check("j3_rst_size", 64'(dma_size), 64'h0);
        rst_n = 1'b1;
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        mmio_read_check("j3_status", 16'h8, 64'h0);
        mmio_read_check("j3_rd_addr", 16'h2, 64'h0);
        mmio_read_check("j3_scratch_rst", 16'hE, 64'h0);
        mmio_write(16'hE, 64'hDEAD_BEEF);
        mmio_read_check("j3_scratch", 16'hE, SCRATCH_EXP);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dma_csr_ctrl.md
Name: dma_csr_ctrl

Overview:
- Downstream consumer of the HAL's simplified MMIO protocol, instantiated inside the afu.
- Decodes MMIO reads and writes into the DMA job registers: read address, write address, size and go.
- Runs a job-control FSM that issues a single-cycle start to the DMA datapath, tracks completion, counts busy cycles, and answers MMIO reads with fixed 1-cycle latency.

Parameters:
- BASE_ADDR, 16'h0050, MMIO word address of register offset 0; must lie within the HAL MMIO range.
- ADDR_WIDTH, 64, width of the DMA address registers, in cache-line address units.
- SIZE_WIDTH, 32, width of the transfer-size register, in cache lines.

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, synchronous, active-low
- mmio_rd_en  in  1  MMIO read strobe, one cycle per read
- mmio_wr_en  in  1  MMIO write strobe, one cycle per write
- mmio_rd_addr  in  16  MMIO read word address
- mmio_wr_addr  in  16  MMIO write word address
- mmio_wr_data  in  64  MMIO write data
- mmio_rd_data  out  64  read data, valid the cycle after mmio_rd_en and held until the next read
- dma_rd_addr  out  ADDR_WIDTH  source address register
- dma_wr_addr  out  ADDR_WIDTH  destination address register
- dma_size  out  SIZE_WIDTH  transfer length register
- dma_go  out  1  one-cycle job start pulse
- dma_done  in  1  datapath completion; level or pulse accepted
- busy  out  1  high while a job is in flight

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset state: all outputs 0, FSM = IDLE, cycle counter = 0, err = 0.
- Register map (offset from BASE_ADDR, word units, 64-bit registers):
  - 0x0 GO: write-only. Writing data bit0 = 1 requests a start. Reads return 0.
  - 0x2 RD_ADDR: R/W.
  - 0x4 WR_ADDR: R/W.
  - 0x6 SIZE: R/W, low SIZE_WIDTH bits; upper bits ignored on write, read as 0.
  - 0x8 STATUS: RO. bit0 = done, bit1 = busy, bit2 = err, bits 63:3 = 0.
  - 0xA CYCLES: RO, busy-cycle count, zero-extended to 64 bits.
  - 0xC CLEAR: write-only. Any write clears done, err and CYCLES when not BUSY. Ignored while BUSY.
- Unmapped or odd offsets: reads return 0, writes are ignored.
- Read path: mmio_rd_data is registered from the decoded rd_addr in the cycle of mmio_rd_en. Latency is exactly 1 cycle. Output holds between reads.
- Read/write collision: a read and a write to the same register in the same cycle returns the pre-write value.
- FSM states: IDLE, BUSY, DONE.
- IDLE, GO write with bit0 = 1: next cycle dma_go = 1 for exactly 1 cycle; state = BUSY; CYCLES cleared to 0.
- BUSY:
  - CYCLES increments every cycle, saturating at all-ones with no wrap.
  - dma_done = 1 moves to DONE; CYCLES stops updating in that same cycle.
  - GO write sets err = 1 and has no other effect.
  - Writes to RD_ADDR, WR_ADDR and SIZE are ignored and set err = 1.
- DONE: status done = 1. A GO write starts a new job exactly as from IDLE and clears done. A CLEAR write returns to IDLE.
- dma_done outside BUSY is ignored.
- busy output = (state == BUSY).
- dma_go is never asserted in two consecutive cycles.
- Asserting rst_n low mid-job forces IDLE on the next edge; registers clear and dma_go is deasserted.
- A GO write with SIZE = 0 is still issued; the datapath is responsible for raising done.

Optional Feature:
- Macro: DMA_CSR_SCRATCH_EN.
- When defined: a 64-bit R/W scratch register exists at offset 0xE, resets to 0 and is writable in any state.
- When undefined: offset 0xE reads 0 and writes are ignored.

Test Plan:
- Reset check: hold rst_n = 0 for 3 cycles, then read offsets 0x0–0xC -> all return 0; dma_go = 0; busy = 0.
- Config and start: write RD_ADDR = 0x1000, WR_ADDR = 0x2000, SIZE = 16, then GO = 1 -> dma_go high exactly one cycle after the write; dma_rd_addr = 0x1000, dma_wr_addr = 0x2000, dma_size = 16; busy = 1.
- Completion and count: assert dma_done 25 cycles after dma_go -> STATUS reads 0x1; CYCLES reads 25 ± 0 per the defined count point; the value is stable on a second read.
- Busy-time protection: write SIZE = 99 and GO while BUSY -> SIZE still reads 16; no second dma_go; STATUS bit2 = 1 after done. A subsequent CLEAR write gives STATUS = 0.
- Read latency: mmio_rd_en to BASE+0x2 -> mmio_rd_data = 0x1000 on the next cycle. Simultaneous write of 0x3000 to RD_ADDR in that cycle -> read returns 0x1000, and a following read returns 0x3000.
- Reset mid-job: drop rst_n while BUSY -> next cycle busy = 0, all registers 0, and a late dma_done is ignored. With DMA_CSR_SCRATCH_EN, offset 0xE write/read 0xDEADBEEF round-trips; without the macro it reads 0.
